// File: rtl/sin400k_nco_pkg.sv
// Shared constants, types and quarter-wave sine table for the 400 kHz quadrature NCO.
// The table is produced by an integer Taylor-series function that is evaluated at elaboration time.
package sin400k_nco_pkg;

   localparam int PHASE_W   = 32;
   localparam int LUT_W     = 12;
   localparam int OUT_W     = 14;
   localparam int IDX_W     = LUT_W - 2;
   localparam int ROM_AW    = IDX_W + 1;
   localparam int ROM_DW    = OUT_W - 1;
   localparam int ROM_DEPTH = (1 << IDX_W) + 1;
   localparam int STAGES    = 4;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

   typedef struct packed {
      logic              neg;
      logic [ROM_AW-1:0] addr;
   } lut_req_t;

   // pi in Q60, taken straight from the hex expansion of pi
   localparam logic [127:0] PI_Q60 = 128'h3243_F6A8_885A_308D;

   // round((2^ROM_DW-1) * sin(pi/2 * j/1024)); the Q60 Taylor sum is accurate far below 1 LSB
   function automatic logic [ROM_DW-1:0] qwave(input logic [ROM_AW-1:0] j);
      logic [127:0] x, term, sum;
      x    = (128'(j) * PI_Q60) >> (IDX_W + 1);
      term = x;
      sum  = x;
      for (int n = 1; n <= 11; n++) begin
         term = (((term * x) >> 60) * x) >> 60;
         term = term / 128'((2 * n) * (2 * n + 1));
         if (n % 2 == 1) sum = sum - term;
         else            sum = sum + term;
      end
      return ROM_DW'((sum * 128'((1 << ROM_DW) - 1) + (128'd1 << 59)) >> 60);
   endfunction

   // Odd quadrants read the table mirrored; the lower half-plane negates
   function automatic lut_req_t lut_req(input quad_e q, input logic [IDX_W-1:0] i);
      lut_req_t r;
      r.neg  = (q == Q2) || (q == Q3);
      r.addr = (q == Q1 || q == Q3) ? ROM_AW'(ROM_DEPTH - 1) - {1'b0, i} : {1'b0, i};
      return r;
   endfunction

   function automatic logic signed [OUT_W-1:0] apply_sign(input logic [ROM_DW-1:0] mag,
                                                          input logic neg);
      logic signed [OUT_W-1:0] ext;
      ext = signed'({1'b0, mag});
      return neg ? -ext : ext;
   endfunction

endpackage

// File: rtl/sin400k_qrom.sv
// Dual-read-port quarter-wave sine ROM with registered outputs, shared by the sine and cosine paths.
module sin400k_qrom
   import sin400k_nco_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic [ROM_AW-1:0] addr_a_i,
   input  logic [ROM_AW-1:0] addr_b_i,
   output logic [ROM_DW-1:0] data_a_o,
   output logic [ROM_DW-1:0] data_b_o
);

   logic [ROM_DW-1:0] rom [ROM_DEPTH];
   logic [ROM_DW-1:0] data_a_q, data_b_q;

   for (genvar j = 0; j < ROM_DEPTH; j++) begin : g_rom
      localparam logic [ROM_DW-1:0] ENTRY = qwave(ROM_AW'(j));
      assign rom[j] = ENTRY;
   end

   // Addresses never exceed ROM_DEPTH-1: lut_req mirrors into 0..1024
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_a_q <= '0;
         data_b_q <= '0;
      end else if (en_i) begin
         data_a_q <= rom[addr_a_i];
         data_b_q <= rom[addr_b_i];
      end
   end

   assign data_a_o = data_a_q;
   assign data_b_o = data_b_q;

endmodule

// File: rtl/sin400k_nco.sv
// Quadrature NCO: 32-bit phase accumulator, 12-bit truncation, quarter-wave lookup, sign stage.
// Four enabled-cycle pipeline; out_valid latches high once the pipe has filled after reset.
module sin400k_nco
   import sin400k_nco_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clken,
   input  logic [PHASE_W-1:0]       phi_inc_i,
   output logic signed [OUT_W-1:0]  fsin_o,
   output logic signed [OUT_W-1:0]  fcos_o,
   output logic                     out_valid
);

   logic [PHASE_W-1:0]      acc_q, acc_d;
   logic [LUT_W-1:0]        ph_q;
   lut_req_t                s_req_q, s_req_d, c_req_q, c_req_d;
   logic                    neg_s_q, neg_c_q;
   logic [ROM_DW-1:0]       rom_s, rom_c;
   logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;
   logic [STAGES-1:0]       vld_pipe_q;
   quad_e                   q_s, q_c;

   // Cosine is sine a quarter turn ahead: same index, quadrant + 1
   always_comb begin
      acc_d   = acc_q + phi_inc_i;
      q_s     = quad_e'(ph_q[LUT_W-1 -: 2]);
      q_c     = quad_e'(ph_q[LUT_W-1 -: 2] + 2'd1);
      s_req_d = lut_req(q_s, ph_q[IDX_W-1:0]);
      c_req_d = lut_req(q_c, ph_q[IDX_W-1:0]);
      sin_d   = apply_sign(rom_s, neg_s_q);
      cos_d   = apply_sign(rom_c, neg_c_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q      <= '0;
         ph_q       <= '0;
         s_req_q    <= '0;
         c_req_q    <= '0;
         neg_s_q    <= 1'b0;
         neg_c_q    <= 1'b0;
         sin_q      <= '0;
         cos_q      <= '0;
         vld_pipe_q <= '0;
      end else if (clken) begin
         acc_q      <= acc_d;
         ph_q       <= acc_q[PHASE_W-1 -: LUT_W];
         s_req_q    <= s_req_d;
         c_req_q    <= c_req_d;
         neg_s_q    <= s_req_q.neg;
         neg_c_q    <= c_req_q.neg;
         sin_q      <= sin_d;
         cos_q      <= cos_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-2:0], 1'b1};
      end
   end

   sin400k_qrom u_qrom (
      .clk      (clk),
      .rst_n    (reset_n),
      .en_i     (clken),
      .addr_a_i (s_req_q.addr),
      .addr_b_i (c_req_q.addr),
      .data_a_o (rom_s),
      .data_b_o (rom_c)
   );

   assign fsin_o    = sin_q;
   assign fcos_o    = cos_q;
   assign out_valid = vld_pipe_q[STAGES-1];

endmodule

// File: tb/tb_sin400k_nco.sv
// Directed bench for sin400k_nco: hand-computed anchor samples plus a real-valued phase model.
module tb_sin400k_nco;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               clken = 1'b0;
   logic [31:0]        phi = 32'h0;
   logic signed [13:0] fsin_o, fcos_o;
   logic               out_valid;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] macc;
   logic [31:0] mph [4];
   logic [3:0]  mv;

   sin400k_nco dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clken     (clken),
      .phi_inc_i (phi),
      .fsin_o    (fsin_o),
      .fcos_o    (fcos_o),
      .out_valid (out_valid)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sq(input int j);
      return $rtoi(8191.0 * $sin(3.141592653589793 * j / 2048.0) + 0.5);
   endfunction

   function automatic int msin(input logic [31:0] ph);
      int i;
      i = int'(ph[29:20]);
      case (ph[31:30])
         2'd0:    return sq(i);
         2'd1:    return sq(1024 - i);
         2'd2:    return -sq(i);
         default: return -sq(1024 - i);
      endcase
   endfunction

   function automatic int mcos(input logic [31:0] ph);
      return msin(ph + 32'h4000_0000);
   endfunction

   task automatic mreset();
      macc = 0;
      mv   = 0;
      for (int k = 0; k < 4; k++) mph[k] = 0;
   endtask

   task automatic mstep();
      if (reset_n && clken) begin
         mph[3] = mph[2];
         mph[2] = mph[1];
         mph[1] = mph[0];
         mph[0] = macc;
         macc   = macc + phi;
         mv     = {mv[2:0], 1'b1};
      end
   endtask

   task automatic cyc(input bit do_chk);
      @(posedge clk);
      mstep();
      @(negedge clk);
      if (do_chk) begin
         chk("valid", out_valid, mv[3]);
         if (mv[3]) begin
            chk("sin", fsin_o, msin(mph[3]));
            chk("cos", fcos_o, mcos(mph[3]));
         end
      end
   endtask

   task automatic restart(input logic [31:0] inc);
      @(negedge clk);
      reset_n = 1'b0;
      mreset();
      @(negedge clk);
      phi     = inc;
      clken   = 1'b1;
      reset_n = 1'b1;
   endtask

   initial begin
      int s, c, zc, bad_rng, bad_pwr, hs, hc, hv;
      real r2;
      bit prev_neg;
      int qs[4] = '{0, 8191, 0, -8191};
      int qc[4] = '{8191, 0, -8191, 0};

      // reset and fill
      mreset();
      repeat (7) @(negedge clk);
      chk("rst_sin", fsin_o, 0);
      chk("rst_cos", fcos_o, 0);
      chk("rst_vld", out_valid, 0);
      reset_n = 1'b1;
      clken   = 1'b1;
      phi     = 32'h020C_49BA;
      for (int e = 1; e <= 5; e++) begin
         cyc(1);
         chk("fill_vld", out_valid, (e >= 4) ? 1 : 0);
         if (e == 4) begin
            chk("s0_sin", fsin_o, 0);
            chk("s0_cos", fcos_o, 8191);
         end
         if (e == 5) begin
            chk("s1_sin", fsin_o, 402);
            chk("s1_cos", fcos_o, 8181);
         end
      end

      // 400 kHz run with waveform statistics
      zc = 0; bad_rng = 0; bad_pwr = 0; prev_neg = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         cyc(1);
         s = fsin_o;
         c = fcos_o;
         if (s > 8191 || s < -8191 || c > 8191 || c < -8191) bad_rng++;
         r2 = real'(s * s + c * c);
         if (r2 < 0.99 * 8191.0 * 8191.0 || r2 > 1.01 * 8191.0 * 8191.0) bad_pwr++;
         if ((s < 0) != prev_neg) zc++;
         prev_neg = (s < 0);
      end
      chk("range", bad_rng, 0);
      chk("power", bad_pwr, 0);
      chk("zero_cross_ok", (zc >= 158 && zc <= 162) ? 1 : 0, 1);

      // clken gating
      hs = fsin_o; hc = fcos_o; hv = out_valid;
      clken = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         chk("hold_sin", fsin_o, hs);
         chk("hold_cos", fcos_o, hc);
         chk("hold_vld", out_valid, hv);
      end
      clken = 1'b1;
      repeat (10) cyc(1);

      // asynchronous mid-run reset
      @(posedge clk);
      mstep();
      #5 reset_n = 1'b0;
      #1;
      chk("arst_sin", fsin_o, 0);
      chk("arst_cos", fcos_o, 0);
      chk("arst_vld", out_valid, 0);
      mreset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         cyc(1);
         chk("refill_vld", out_valid, (e >= 4) ? 1 : 0);
         if (e == 4) begin
            chk("refill_sin", fsin_o, 0);
            chk("refill_cos", fcos_o, 8191);
         end
      end

      // quadrant walk
      restart(32'h4000_0000);
      repeat (3) cyc(1);
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         chk("qw_sin", fsin_o, qs[k % 4]);
         chk("qw_cos", fcos_o, qc[k % 4]);
      end

      // reverse increment with wrap, then switch to one LUT step per sample
      restart(32'hFFFF_FFFF);
      for (int e = 1; e <= 12; e++) begin
         cyc(1);
         if (e == 5 || e == 9) begin
            chk("wrap_sin", fsin_o, -13);
            chk("wrap_cos", fcos_o, 8191);
         end
         if (e == 5) phi = 32'h0010_0000;
         if (e == 10) chk("step0_sin", fsin_o, 0);
         if (e == 11) chk("step1_sin", fsin_o, 13);
         if (e == 12) chk("step2_sin", fsin_o, 25);
         if (e >= 10) chk("step_cos", fcos_o, 8191);
      end
      repeat (50) cyc(1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sin400k_nco.md
# sin400k_nco

Numerically controlled oscillator that produces a quadrature pair of 14-bit two's-complement sine/cosine samples from a 32-bit phase-increment word. It is clocked at 50 MHz and normally driven with phase increment 0x020C49BA, which gives a 400 kHz reference tone. Downstream modulation and demodulation logic uses that tone. The block runs one sample per enabled clock and flags valid output once its pipeline has filled after reset.

## Interface
- PHASE_W, 32: phase accumulator width.
- LUT_W, 12: phase bits kept after truncation for lookup.
- OUT_W, 14: output sample width, signed.
- clk, in, 1: single clock (50 MHz nominal).
- reset_n, in, 1: reset, asynchronous, active-low.
- clken, in, 1: clock enable. When low, all state freezes.
- phi_inc_i, in, 32: unsigned phase increment, sampled every enabled cycle.
- fsin_o, out, 14: sine sample, two's complement.
- fcos_o, out, 14: cosine sample, two's complement.
- out_valid, out, 1: high while fsin_o/fcos_o carry valid samples.

## Operation
- Accumulator: on each enabled cycle, acc <= acc + phi_inc_i, modulo 2^32. The pre-add value of acc enters the pipeline. Sample k therefore has phase k·phi_inc, sample 0 has phase 0. This holds while phi_inc is constant.
- Truncation: p = acc[31:20] (12 bits, no dither). q = p[11:10] is the quadrant, i = p[9:0] is the in-quadrant index.
- Quarter-wave ROM S[j], j = 0..1024 (1025 entries, 13-bit unsigned), S[j] = round(8191·sin(π/2·j/1024)). S[0] = 0, S[1024] = 8191.
- Sine by quadrant:
  - q0: +S[i]
  - q1: +S[1024−i]
  - q2: −S[i]
  - q3: −S[1024−i]
- Cosine is sine evaluated at p+1024 (mod 4096). It uses the second read port of the same ROM.
- Output range is ±8191. −8192 is never produced. Negation is exact two's complement.
- Output frequency = f_clk·phi_inc/2^32. 0x020C49BA at 50 MHz gives about 400.0 kHz, roughly 125 samples per period.
- phi_inc_i may change at any enabled cycle. The new increment takes effect on the next accumulation. There is no phase reset.

## Timing
- On reset: acc = 0, all pipeline registers = 0, fsin_o = 0, fcos_o = 0, out_valid = 0.
- Pipeline, counted in enabled cycles:
  - Stage 1: accumulator register.
  - Stage 2: quadrant decode and ROM address registers.
  - Stage 3: ROM output registers.
  - Stage 4: sign-applied output registers.
- Latency from phase to output is 3 enabled cycles after the accumulator.
- out_valid rises on the 4th enabled rising edge after reset_n deasserts. It then stays high until the next reset.
- The first valid sample is phase 0: fsin_o = 0, fcos_o = 8191.
- clken low: accumulator, pipeline, valid counter and outputs all hold. out_valid keeps its value. Sample spacing counts enabled edges only.
- Asserting reset mid-operation clears everything immediately (asynchronously). Deassertion is synchronized to the clk edge.
- Accumulator wrap past 2^32 is silent and continuous.

## Structure
- Shared package holds:
  - PHASE_W, LUT_W, OUT_W.
  - The quarter-wave ROM contents as a constant array or function. It is generated offline, 1025 × 13 bits.
  - The quadrant enum (Q0–Q3).
- One sub-module, sin400k_qrom: dual-read-port synchronous quarter-wave ROM with registered outputs. It is instantiated once and shared by the sine and cosine paths.
- The top level contains the accumulator, quadrant and index logic, sign stage and valid counter.

## Test plan
- Reset and fill: reset_n low for 7 cycles, then high, clken = 1, phi = 0x020C49BA.
  - out_valid = 0 for the first 3 edges and goes high on the 4th.
  - First sample is sin 0 / cos 8191. Second is sin 402 / cos 8181.
- Quadrant walk: phi = 0x40000000.
  - sin sequence 0, 8191, 0, −8191, repeating.
  - cos sequence 8191, 0, −8191, 0, repeating.
- 400 kHz run: phi = 0x020C49BA for 10,000 samples.
  - Every sample equals the reference model within ±0 LSB.
  - Zero crossings are about 62.5 samples apart. No value outside ±8191.
  - sin² + cos² stays within 1% of 8191².
- clken gating: drop clken for 5 cycles mid-stream.
  - Outputs and out_valid hold.
  - After re-enable, the sequence resumes with no skipped or repeated phase.
- Mid-run reset: pulse reset_n low asynchronously between clock edges.
  - Outputs = 0 and out_valid = 0 immediately.
  - After release, the sequence restarts from phase 0 with a 4-edge fill.
- Increment change and wrap: phi = 0xFFFFFFFF, then switch to 0x00100000.
  - First run: sin steps through −1 LSB-phase values with correct wrap.
  - After the switch, phase advances 1 LUT step per sample from the current accumulator value.
